// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan controller: index width and FSM state encoding.
package decoder_pkg;

    localparam int IDX_W   = 3;
    localparam int MAX_IDX = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

endpackage

// File: rtl/decoder_scan_ctrl_timer.sv
// Holdable, clearable up counter that rolls over to zero after TERM counts; tc flags the last count.
module decoder_scan_timer
    import decoder_pkg::*;
#(
    parameter int TERM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    output logic tc
);

    localparam int W = $clog2(TERM + 1);

    logic [W-1:0] count_reg;

    // clr wins over adv; rolling over on tc keeps the count within 0..TERM-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (adv) begin
            count_reg <= tc ? '0 : count_reg + W'(1);
        end
    end

    assign tc = (count_reg == W'(TERM - 1));

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan index generator feeding a 3x8 decoder's select inputs.
// Define DECODER_SCAN_BLANK_EN to insert BLANK_CYC blanking cycles after every index change.
module decoder_scan_ctrl
    import decoder_pkg::*;
#(
    parameter int DWELL     = 4,
    parameter int NUM_ACT   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             hold,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    output logic             dout_a,
    output logic             dout_b,
    output logic             dout_c,
    output logic             blank,
    output logic             wrap
);

    if (DWELL < 1 || DWELL > 65535 || NUM_ACT < 1 || NUM_ACT > MAX_IDX + 1 ||
        BLANK_CYC < 1 || BLANK_CYC > 255) begin : g_bad_params
        $error("decoder_scan_ctrl: parameter out of range");
    end

    localparam int                NUM_ACT_C = (NUM_ACT > MAX_IDX + 1) ? MAX_IDX + 1 : NUM_ACT;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ACT_C - 1);

    scan_state_t      state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             blank_reg, blank_next;
    logic             wrap_reg, wrap_next;
    logic             dwell_clr, dwell_adv, dwell_tc;
    logic [IDX_W-1:0] load_tgt, adv_idx;

    // Out-of-range load targets fall back to the first index
    assign load_tgt = (32'(load_idx) >= NUM_ACT_C) ? '0 : load_idx;
    assign adv_idx  = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);

    decoder_scan_timer #(.TERM(DWELL)) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (dwell_clr),
        .adv (dwell_adv),
        .tc  (dwell_tc)
    );

`ifdef DECODER_SCAN_BLANK_EN
    logic blank_clr, blank_adv, blank_tc;

    decoder_scan_timer #(.TERM(BLANK_CYC)) u_blank (
        .clk (clk),
        .rst (rst),
        .clr (blank_clr),
        .adv (blank_adv),
        .tc  (blank_tc)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            blank_reg <= 1'b1;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            blank_reg <= blank_next;
            wrap_reg  <= wrap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        blank_next = blank_reg;
        wrap_next  = 1'b0;
        dwell_clr  = 1'b0;
        dwell_adv  = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
        blank_clr  = 1'b0;
        blank_adv  = 1'b0;
`endif
        if (!en) begin
            state_next = ST_IDLE;
            blank_next = 1'b1;
            dwell_clr  = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load) begin
                        idx_next = load_tgt;
                    end else begin
                        state_next = ST_SCAN;
                        blank_next = 1'b0;
                        dwell_clr  = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (load) begin
                        idx_next   = load_tgt;
                        blank_next = 1'b0;
                        dwell_clr  = 1'b1;
                    end else if (!hold) begin
                        dwell_adv = 1'b1;
                        if (dwell_tc) begin
                            idx_next  = adv_idx;
                            wrap_next = (idx_reg == LAST_IDX);
`ifdef DECODER_SCAN_BLANK_EN
                            state_next = ST_BLANK;
                            blank_next = 1'b1;
                            blank_clr  = 1'b1;
`endif
                        end
                    end
                end
`ifdef DECODER_SCAN_BLANK_EN
                ST_BLANK: begin
                    // The dwell timer already rolled to zero on entry, so it only needs clearing on load
                    if (load) begin
                        state_next = ST_SCAN;
                        idx_next   = load_tgt;
                        blank_next = 1'b0;
                        dwell_clr  = 1'b1;
                    end else if (!hold) begin
                        blank_adv = 1'b1;
                        if (blank_tc) begin
                            state_next = ST_SCAN;
                            blank_next = 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    state_next = ST_IDLE;
                    blank_next = 1'b1;
                    dwell_clr  = 1'b1;
                end
            endcase
        end
    end

    assign dout_a = idx_reg[0];
    assign dout_b = idx_reg[1];
    assign dout_c = idx_reg[2];
    assign blank  = blank_reg;
    assign wrap   = wrap_reg;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench: three scan controllers (8x4, 5x4, 1x1) against a behavioural scan model.
module tb_decoder_scan_ctrl;

    localparam int DWELL     = 4;
    localparam int BLANK_CYC = 2;
`ifdef DECODER_SCAN_BLANK_EN
    localparam int BLANK_ON  = 1;
`else
    localparam int BLANK_ON  = 0;
`endif
    localparam int PERIOD    = DWELL + BLANK_ON * BLANK_CYC;
    localparam int NDUT      = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       hold = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_idx = 3'd0;

    logic a0, b0, c0, bl0, wr0;
    logic a1, b1, c1, bl1, wr1;
    logic a2, b2, c2, bl2, wr2;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DWELL(DWELL), .NUM_ACT(8), .BLANK_CYC(BLANK_CYC)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .load(load), .load_idx(load_idx),
        .dout_a(a0), .dout_b(b0), .dout_c(c0), .blank(bl0), .wrap(wr0));

    decoder_scan_ctrl #(.DWELL(DWELL), .NUM_ACT(5), .BLANK_CYC(BLANK_CYC)) u_dut5 (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .load(load), .load_idx(load_idx),
        .dout_a(a1), .dout_b(b1), .dout_c(c1), .blank(bl1), .wrap(wr1));

    decoder_scan_ctrl #(.DWELL(1), .NUM_ACT(1), .BLANK_CYC(BLANK_CYC)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .load(load), .load_idx(load_idx),
        .dout_a(a2), .dout_b(b2), .dout_c(c2), .blank(bl2), .wrap(wr2));

    int n_checks = 0;
    int n_errors = 0;

    // Model: index, counted dwell cycles so far, blanking cycles still owed
    int na[NDUT] = '{8, 5, 1};
    int dw[NDUT] = '{DWELL, DWELL, 1};
    int m_idx[NDUT];
    int m_el[NDUT];
    int m_bl[NDUT];
    int m_act[NDUT];
    int m_blank[NDUT];
    int m_wrap[NDUT];

    function automatic int dut_idx(input int k);
        case (k)
            0:       return int'({c0, b0, a0});
            1:       return int'({c1, b1, a1});
            default: return int'({c2, b2, a2});
        endcase
    endfunction

    function automatic int dut_blank(input int k);
        case (k)
            0:       return int'(bl0);
            1:       return int'(bl1);
            default: return int'(bl2);
        endcase
    endfunction

    function automatic int dut_wrap(input int k);
        case (k)
            0:       return int'(wr0);
            1:       return int'(wr1);
            default: return int'(wr2);
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_idx[k] = 0; m_el[k] = 0; m_bl[k] = 0;
            m_act[k] = 0; m_blank[k] = 1; m_wrap[k] = 0;
        end
    endtask

    task automatic model_step();
        int tgt;
        for (int k = 0; k < NDUT; k++) begin
            tgt = (int'(load_idx) >= na[k]) ? 0 : int'(load_idx);
            m_wrap[k] = 0;
            if (!en) begin
                m_act[k] = 0; m_el[k] = 0; m_bl[k] = 0; m_blank[k] = 1;
            end else if (m_act[k] == 0) begin
                if (load) m_idx[k] = tgt;
                else begin
                    m_act[k] = 1; m_el[k] = 0; m_blank[k] = 0;
                end
            end else if (load) begin
                m_idx[k] = tgt; m_el[k] = 0; m_bl[k] = 0; m_blank[k] = 0;
            end else if (!hold) begin
                if (m_bl[k] > 0) begin
                    m_bl[k]--;
                    if (m_bl[k] == 0) begin
                        m_blank[k] = 0; m_el[k] = 0;
                    end
                end else begin
                    m_el[k]++;
                    if (m_el[k] == dw[k]) begin
                        m_el[k]   = 0;
                        m_wrap[k] = (m_idx[k] == na[k] - 1) ? 1 : 0;
                        m_idx[k]  = (m_idx[k] + 1) % na[k];
                        if (BLANK_ON != 0) begin
                            m_bl[k] = BLANK_CYC; m_blank[k] = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("dut%0d idx", k), dut_idx(k), m_idx[k]);
            check($sformatf("dut%0d blank", k), dut_blank(k), m_blank[k]);
            check($sformatf("dut%0d wrap", k), dut_wrap(k), m_wrap[k]);
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int wraps, changes, prev;
        model_reset();

        step();
        step();
        check("reset idx", dut_idx(0), 0);
        check("reset blank", dut_blank(0), 1);
        check("reset wrap", dut_wrap(0), 0);
        $display("reset done");

        rst = 1'b0;
        step();
        en = 1'b1;
        step();
        check("en latency blank", dut_blank(0), 0);
        check("en latency idx", dut_idx(0), 0);

        wraps = 0; changes = 0; prev = dut_idx(0);
        for (int i = 0; i < 8 * PERIOD; i++) begin
            step();
            if (wr0) begin
                wraps++;
                check("idx at wrap", dut_idx(0), 0);
            end
            if (dut_idx(0) != prev) changes++;
            prev = dut_idx(0);
        end
        check("lap wrap count", wraps, 1);
        check("lap idx changes", changes, 8);
        check("lap end idx", dut_idx(0), 0);
        $display("full lap done: %0d index changes, %0d wraps", changes, wraps);

        load_idx = 3'd3; load = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        hold = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("hold idx frozen", dut_idx(0), 3);
        hold = 1'b0;
        step();
        check("hold dwell remain", dut_idx(0), 3);
        step();
        check("hold dwell expire", dut_idx(0), 4);
        $display("hold test done");

        load_idx = 3'd5; load = 1'b1;
        step();
        load = 1'b0;
        check("load 5 on 5-index", dut_idx(1), 0);
        step();
        step();
        en = 1'b0;
        step();
        check("disable blank", dut_blank(0), 1);
        check("disable idx", dut_idx(0), 5);
        step();
        step();
        en = 1'b1;
        step();
        check("reenable blank", dut_blank(0), 0);
        check("reenable idx", dut_idx(0), 5);
        step();
        step();
        step();
        check("reenable full dwell", dut_idx(0), 5);
        step();
        check("reenable advance", dut_idx(0), 6);
        $display("enable drop test done");

        load_idx = 3'd6; load = 1'b1;
        step();
        load = 1'b0;
        check("load 6 clamps", dut_idx(1), 0);
        check("load no wrap", dut_wrap(1), 0);
        check("load 6 on 8-index", dut_idx(0), 6);
        check("load clears blank", dut_blank(0), 0);
        step();

        #2 rst = 1'b1;
        #1;
        check("async rst idx", dut_idx(0), 0);
        check("async rst blank", dut_blank(0), 1);
        check("async rst wrap", dut_wrap(0), 0);
        model_reset();
        step();
        rst = 1'b0;
        $display("async reset test done");

        step();
        for (int i = 0; i < DWELL; i++) step();
`ifdef DECODER_SCAN_BLANK_EN
        check("blank after dwell", dut_blank(0), 1);
        check("blank shows next idx", dut_idx(0), 1);
        load_idx = 3'd2; load = 1'b1;
        step();
        load = 1'b0;
        check("load aborts blank", dut_blank(0), 0);
        check("load in blank idx", dut_idx(0), 2);
`else
        check("no blank after dwell", dut_blank(0), 0);
        check("advance after dwell", dut_idx(0), 1);
`endif

        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 99) < 95);
            hold     = ($urandom_range(0, 99) < 10);
            load     = ($urandom_range(0, 99) < 5);
            load_idx = 3'($urandom_range(0, 7));
            step();
        end
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
